regwb_arbiter: RTL and testbench

REGWB_ARBITER -- requirements
Module: regwb_arbiter

---
 rtl/regwb_arbiter.sv | 150 +++++++++++++++
 tb/tb_regwb_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/regwb_arbiter.sv
// regwb_arbiter
//   Merges two register-file writeback streams (s0 = execute, s1 = memory)
//   onto a single register-file write port.
//   Each requester owns a one-entry holding buffer.
//   Buffered writes are arbitrated round-robin.
//   When both buffers target the same register, the older write wins so that
//   program order is preserved for that register.
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   s0_valid/ready/rd_addr/rd_data  requester 0 offer (valid/ready handshake)
//   s1_valid/ready/rd_addr/rd_data  requester 1 offer
//   reg_write, rd_addr, rd_data   registered register-file write port
//   busy_mask                     per-register pending-write flags
//                                 (only with REGWB_BUSY_MASK_EN defined)
//
// Configuration
//   REGWB_BUSY_MASK_EN  adds the busy_mask output and its logic.

module regwb_arbiter #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [4:0]        s0_rd_addr,
    input  logic [DATA_W-1:0] s0_rd_data,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [4:0]        s1_rd_addr,
    input  logic [DATA_W-1:0] s1_rd_data,
    output logic              reg_write,
    output logic [4:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data
`ifdef REGWB_BUSY_MASK_EN
    ,
    output logic [31:0]       busy_mask
`endif
);

    logic              buf0_valid, buf1_valid;
    logic [4:0]        buf0_addr,  buf1_addr;
    logic [DATA_W-1:0] buf0_data,  buf1_data;
    logic              rr_ptr;
    // Set when buffer 1 holds the older write; only meaningful while both are valid.
    logic              old1;

    logic grant0, grant1;
    logic acc0, acc1, load0, load1, stay0, stay1;

    // Arbitration
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (buf0_valid && buf1_valid) begin
            if (buf0_addr == buf1_addr) begin
                // Same destination: order matters, age overrides round-robin.
                grant1 = old1;
                grant0 = !old1;
            end else begin
                grant1 = rr_ptr;
                grant0 = !rr_ptr;
            end
        end else begin
            grant0 = buf0_valid;
            grant1 = buf1_valid;
        end
    end

    // Ready depends only on state (and reset), never on the offer itself.
    // A buffer being drained this cycle can reload on the same edge.
    assign s0_ready = !rst && (!buf0_valid || grant0);
    assign s1_ready = !rst && (!buf1_valid || grant1);

    assign acc0  = s0_valid && s0_ready;
    assign acc1  = s1_valid && s1_ready;
    // Writes to x0 are accepted but dropped here.
    assign load0 = acc0 && (s0_rd_addr != 5'd0);
    assign load1 = acc1 && (s1_rd_addr != 5'd0);
    assign stay0 = buf0_valid && !grant0;
    assign stay1 = buf1_valid && !grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf0_valid <= 1'b0;
            buf0_addr  <= '0;
            buf0_data  <= '0;
            buf1_valid <= 1'b0;
            buf1_addr  <= '0;
            buf1_data  <= '0;
            rr_ptr     <= 1'b0;
            old1       <= 1'b0;
            reg_write  <= 1'b0;
            rd_addr    <= '0;
            rd_data    <= '0;
        end else begin
            if (load0) begin
                buf0_valid <= 1'b1;
                buf0_addr  <= s0_rd_addr;
                buf0_data  <= s0_rd_data;
            end else if (grant0) begin
                buf0_valid <= 1'b0;
            end

            if (load1) begin
                buf1_valid <= 1'b1;
                buf1_addr  <= s1_rd_addr;
                buf1_data  <= s1_rd_data;
            end else if (grant1) begin
                buf1_valid <= 1'b0;
            end

            // Age tracking.
            // A buffer loaded alongside a surviving entry is the younger one.
            // A simultaneous load treats buffer 1 as the older write.
            if (load0 && load1)
                old1 <= 1'b1;
            else if (load0 && stay1)
                old1 <= 1'b1;
            else if (load1 && stay0)
                old1 <= 1'b0;

            // Round-robin pointer moves only under contention, to the loser.
            if (buf0_valid && buf1_valid)
                rr_ptr <= grant0;

            reg_write <= grant0 || grant1;
            if (grant0) begin
                rd_addr <= buf0_addr;
                rd_data <= buf0_data;
            end else if (grant1) begin
                rd_addr <= buf1_addr;
                rd_data <= buf1_data;
            end
        end
    end

`ifdef REGWB_BUSY_MASK_EN
    always_comb begin
        busy_mask = '0;
        for (int r = 1; r < 32; r++) begin
            busy_mask[r] = (buf0_valid && (buf0_addr == 5'(r))) ||
                           (buf1_valid && (buf1_addr == 5'(r))) ||
                           (reg_write  && (rd_addr   == 5'(r)));
        end
    end
`endif

endmodule

// File: tb/tb_regwb_arbiter.sv
module tb_regwb_arbiter;

    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              s0_valid, s1_valid;
    logic              s0_ready, s1_ready;
    logic [4:0]        s0_rd_addr, s1_rd_addr;
    logic [DATA_W-1:0] s0_rd_data, s1_rd_data;
    logic              reg_write;
    logic [4:0]        rd_addr;
    logic [DATA_W-1:0] rd_data;
`ifdef REGWB_BUSY_MASK_EN
    logic [31:0]       busy_mask;
`endif

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regwb_arbiter #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .s0_valid   (s0_valid),
        .s0_ready   (s0_ready),
        .s0_rd_addr (s0_rd_addr),
        .s0_rd_data (s0_rd_data),
        .s1_valid   (s1_valid),
        .s1_ready   (s1_ready),
        .s1_rd_addr (s1_rd_addr),
        .s1_rd_data (s1_rd_data),
        .reg_write  (reg_write),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
`ifdef REGWB_BUSY_MASK_EN
        ,
        .busy_mask  (busy_mask)
`endif
    );

    // Advance one edge; outputs are then examined 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s0_valid = 0; s0_rd_addr = 0; s0_rd_data = 0;
        s1_valid = 0; s1_rd_addr = 0; s1_rd_data = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        #1;
        n_run++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin n_fail++;
            $display("FAIL reset_ready_low: got %b%b want 00", s0_ready, s1_ready); end
        tick();
        n_run++; if (reg_write !== 1'b0) begin n_fail++;
            $display("FAIL reset_reg_write: got %b want 0", reg_write); end
        n_run++; if (rd_addr !== 5'd0 || rd_data !== '0) begin n_fail++;
            $display("FAIL reset_rd: got addr %0d data %h want 0/0", rd_addr, rd_data); end
`ifdef REGWB_BUSY_MASK_EN
        n_run++; if (busy_mask !== 32'h0) begin n_fail++;
            $display("FAIL reset_busy_mask: got %h want 0", busy_mask); end
`endif
        rst = 0;
        #1;
        n_run++; if (s0_ready !== 1'b1 || s1_ready !== 1'b1) begin n_fail++;
            $display("FAIL post_reset_ready: got %b%b want 11", s0_ready, s1_ready); end
    endtask

    // s0 writes x5 = 0x1234; check 2-edge latency and single-cycle pulse.
    task automatic test_single_write();
        do_reset();
        s0_valid = 1; s0_rd_addr = 5; s0_rd_data = 64'h1234;
        tick();                       // edge 1: accepted
        idle_inputs();
        n_run++; if (reg_write !== 1'b0) begin n_fail++;
            $display("FAIL single_early: reg_write got %b want 0", reg_write); end
`ifdef REGWB_BUSY_MASK_EN
        n_run++; if (busy_mask !== 32'h20) begin n_fail++;
            $display("FAIL single_busy_buf: got %h want 00000020", busy_mask); end
`endif
        tick();                       // edge 2: write issued
        n_run++; if (reg_write !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 64'h1234) begin n_fail++;
            $display("FAIL single_write: got we=%b addr=%0d data=%h want 1/5/1234", reg_write, rd_addr, rd_data); end
`ifdef REGWB_BUSY_MASK_EN
        n_run++; if (busy_mask !== 32'h20) begin n_fail++;
            $display("FAIL single_busy_out: got %h want 00000020", busy_mask); end
`endif
        tick();                       // edge 3
        n_run++; if (reg_write !== 1'b0 || rd_addr !== 5'd5 || rd_data !== 64'h1234) begin n_fail++;
            $display("FAIL single_after: got we=%b addr=%0d data=%h want 0/5/1234", reg_write, rd_addr, rd_data); end
`ifdef REGWB_BUSY_MASK_EN
        n_run++; if (busy_mask !== 32'h0) begin n_fail++;
            $display("FAIL single_busy_clear: got %h want 0", busy_mask); end
`endif
    endtask

    // Both requesters always valid, distinct addresses: strict alternation.
    task automatic test_round_robin();
        do_reset();
        s0_valid = 1; s0_rd_addr = 3; s0_rd_data = 64'h33;
        s1_valid = 1; s1_rd_addr = 4; s1_rd_data = 64'h44;
        for (int c = 1; c <= 7; c++) begin
            tick();
            n_run++; if (s0_ready !== ((c % 2) == 1) || s1_ready !== ((c % 2) == 0)) begin n_fail++;
                $display("FAIL rr_ready_e%0d: got %b%b want %b%b", c, s0_ready, s1_ready,
                         (c % 2) == 1, (c % 2) == 0); end
            if (c >= 2) begin
                n_run++;
                if (reg_write !== 1'b1 || rd_addr !== ((c % 2 == 0) ? 5'd3 : 5'd4) ||
                    rd_data !== ((c % 2 == 0) ? 64'h33 : 64'h44)) begin n_fail++;
                    $display("FAIL rr_write_e%0d: got we=%b addr=%0d data=%h want addr %0d", c,
                             reg_write, rd_addr, rd_data, (c % 2 == 0) ? 3 : 4); end
            end
        end
        idle_inputs();
    endtask

    // Same register on the same edge: buffer 1 is older and goes first.
    task automatic test_same_addr();
        do_reset();
        s0_valid = 1; s0_rd_addr = 7; s0_rd_data = 64'hA;
        s1_valid = 1; s1_rd_addr = 7; s1_rd_data = 64'hB;
        tick();
        idle_inputs();
        tick();
        n_run++; if (reg_write !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 64'hB) begin n_fail++;
            $display("FAIL same_addr_first: got we=%b addr=%0d data=%h want 1/7/b", reg_write, rd_addr, rd_data); end
        tick();
        n_run++; if (reg_write !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 64'hA) begin n_fail++;
            $display("FAIL same_addr_second: got we=%b addr=%0d data=%h want 1/7/a", reg_write, rd_addr, rd_data); end
        tick();
        n_run++; if (reg_write !== 1'b0) begin n_fail++;
            $display("FAIL same_addr_done: reg_write got %b want 0", reg_write); end
    endtask

    // x0 write accepted and dropped.
    task automatic test_addr_zero();
        do_reset();
        s1_valid = 1; s1_rd_addr = 0; s1_rd_data = 64'hFF;
        #1;
        n_run++; if (s1_ready !== 1'b1) begin n_fail++;
            $display("FAIL x0_ready: got %b want 1", s1_ready); end
        tick();
        idle_inputs();
        #1;
        n_run++; if (s1_ready !== 1'b1 || reg_write !== 1'b0) begin n_fail++;
            $display("FAIL x0_not_loaded: got ready=%b we=%b want 1/0", s1_ready, reg_write); end
        for (int c = 0; c < 2; c++) begin
            tick();
            n_run++; if (reg_write !== 1'b0) begin n_fail++;
                $display("FAIL x0_no_write_%0d: reg_write got %b want 0", c, reg_write); end
`ifdef REGWB_BUSY_MASK_EN
            n_run++; if (busy_mask !== 32'h0) begin n_fail++;
                $display("FAIL x0_busy_%0d: got %h want 0", c, busy_mask); end
`endif
        end
    endtask

    // One requester streaming: drained and reloaded each edge, no bubbles.
    task automatic test_back_to_back();
        do_reset();
        s0_valid = 1; s0_rd_addr = 9;
        for (int k = 1; k <= 5; k++) begin
            s0_rd_data = 64'h100 + 64'(k);
            tick();                   // edge k accepts data 0x100+k
            n_run++; if (s0_ready !== 1'b1) begin n_fail++;
                $display("FAIL b2b_ready_e%0d: got %b want 1", k, s0_ready); end
            if (k >= 2) begin
                n_run++; if (reg_write !== 1'b1 || rd_data !== 64'h100 + 64'(k - 1)) begin n_fail++;
                    $display("FAIL b2b_write_e%0d: got we=%b data=%h want 1/%h", k, reg_write, rd_data,
                             64'h100 + 64'(k - 1)); end
            end
        end
        idle_inputs();
        tick();
        n_run++; if (reg_write !== 1'b1 || rd_data !== 64'h105) begin n_fail++;
            $display("FAIL b2b_last: got we=%b data=%h want 1/105", reg_write, rd_data); end
    endtask

    // Both buffers full, then a one-cycle reset: nothing buffered survives.
    task automatic test_reset_mid();
        do_reset();
        s0_valid = 1; s0_rd_addr = 10; s0_rd_data = 64'h10;
        s1_valid = 1; s1_rd_addr = 11; s1_rd_data = 64'h11;
        tick();                       // both buffers loaded
        idle_inputs();
        rst = 1;
        #1;
        n_run++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin n_fail++;
            $display("FAIL mid_rst_ready: got %b%b want 00", s0_ready, s1_ready); end
        tick();
        rst = 0;
        #1;
        n_run++; if (reg_write !== 1'b0) begin n_fail++;
            $display("FAIL mid_rst_we: got %b want 0", reg_write); end
        n_run++; if (s0_ready !== 1'b1 || s1_ready !== 1'b1) begin n_fail++;
            $display("FAIL mid_rst_empty: got %b%b want 11", s0_ready, s1_ready); end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_run++; if (reg_write !== 1'b0) begin n_fail++;
                $display("FAIL mid_rst_leak_%0d: got we=%b addr=%0d want 0", c, reg_write, rd_addr); end
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_single_write();
        test_round_robin();
        test_same_addr();
        test_addr_zero();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
